// File: rtl/ps2_matrix_if.sv
// ps2_matrix_if -- byte strobe in from the PS/2 receiver, ZX row address in,
// column data and hotkey pulses out.
//   kstb  : one-cycle strobe, code holds a new raw PS/2 byte
//   code  : raw PS/2 set-2 byte
//   a     : ZX address high byte, active-low row selects
//   q     : active-low column data for the port-FE read
//   nmi   : one-cycle NMI hotkey pulse
//   rst   : one-cycle Ctrl+Alt+Del pulse
interface ps2_matrix_if;
  logic       kstb;
  logic [7:0] code;
  logic [7:0] a;
  logic [4:0] q;
  logic       nmi;
  logic       rst;

  modport master (output kstb, code, a, input q, nmi, rst);
  modport slave  (input kstb, code, a, output q, nmi, rst);
endinterface

// File: rtl/ps2_matrix.sv
// ps2_matrix -- PS/2 set-2 scancode parser feeding a ZX Spectrum 8x5 matrix.
// Handles E0/F0/E1 prefixes and BAT/error flush bytes, reference-counts the
// shared CAPS SHIFT and SYMBOL SHIFT keys, and emits NMI / reset hotkeys.
//   clock : system clock, all state on the rising edge
//   reset : asynchronous active-low reset
//   bus   : ps2_matrix_if slave (kstb/code in, a in, q/nmi/rst out)
module ps2_matrix #(
  parameter int unsigned CNTW     = 3,
  parameter logic [7:0]  NMI_CODE = 8'h03,
  parameter int unsigned E1_SKIP  = 7
) (
  input logic         clock,
  input logic         reset,
  ps2_matrix_if.slave bus
);

  localparam int unsigned SKW = (E1_SKIP < 2) ? 1 : $clog2(E1_SKIP + 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_EXT, S_BRK, S_EXTBRK, S_SKIP} state_t;
  typedef struct packed { logic hit; logic [2:0] row; logic [2:0] col; } pos_t;
  typedef struct packed { logic hit; logic [2:0] idx; } cs_t;
  typedef struct packed { logic hit; logic [3:0] idx; } ss_t;

  function automatic pos_t rc(input logic [2:0] r, input logic [2:0] c);
    rc = '{hit: 1'b1, row: r, col: c};
  endfunction

  // Matrix position driven by a code; combination partners share this table.
  function automatic pos_t plain_map(input logic [7:0] c);
    plain_map = '0;
    case (c)
      8'h1A: plain_map = rc(3'd0, 3'd1); 8'h22: plain_map = rc(3'd0, 3'd2);
      8'h21: plain_map = rc(3'd0, 3'd3); 8'h2A: plain_map = rc(3'd0, 3'd4);
      8'h1C: plain_map = rc(3'd1, 3'd0); 8'h1B: plain_map = rc(3'd1, 3'd1);
      8'h23: plain_map = rc(3'd1, 3'd2); 8'h2B: plain_map = rc(3'd1, 3'd3);
      8'h34: plain_map = rc(3'd1, 3'd4);
      8'h15: plain_map = rc(3'd2, 3'd0); 8'h1D: plain_map = rc(3'd2, 3'd1);
      8'h24: plain_map = rc(3'd2, 3'd2); 8'h2D: plain_map = rc(3'd2, 3'd3);
      8'h2C: plain_map = rc(3'd2, 3'd4);
      8'h16: plain_map = rc(3'd3, 3'd0); 8'h1E: plain_map = rc(3'd3, 3'd1);
      8'h26: plain_map = rc(3'd3, 3'd2); 8'h25: plain_map = rc(3'd3, 3'd3);
      8'h2E: plain_map = rc(3'd3, 3'd4); 8'h6B: plain_map = rc(3'd3, 3'd4);
      8'h45: plain_map = rc(3'd4, 3'd0); 8'h46: plain_map = rc(3'd4, 3'd1);
      8'h3E: plain_map = rc(3'd4, 3'd2); 8'h3D: plain_map = rc(3'd4, 3'd3);
      8'h36: plain_map = rc(3'd4, 3'd4); 8'h66: plain_map = rc(3'd4, 3'd0);
      8'h74: plain_map = rc(3'd4, 3'd2); 8'h75: plain_map = rc(3'd4, 3'd3);
      8'h72: plain_map = rc(3'd4, 3'd4);
      8'h4D: plain_map = rc(3'd5, 3'd0); 8'h44: plain_map = rc(3'd5, 3'd1);
      8'h43: plain_map = rc(3'd5, 3'd2); 8'h3C: plain_map = rc(3'd5, 3'd3);
      8'h35: plain_map = rc(3'd5, 3'd4); 8'h54: plain_map = rc(3'd5, 3'd0);
      8'h52: plain_map = rc(3'd5, 3'd1);
      8'h5A: plain_map = rc(3'd6, 3'd0); 8'h4B: plain_map = rc(3'd6, 3'd1);
      8'h42: plain_map = rc(3'd6, 3'd2); 8'h3B: plain_map = rc(3'd6, 3'd3);
      8'h33: plain_map = rc(3'd6, 3'd4); 8'h4A: plain_map = rc(3'd6, 3'd3);
      8'h5B: plain_map = rc(3'd6, 3'd2);
      8'h29: plain_map = rc(3'd7, 3'd0); 8'h3A: plain_map = rc(3'd7, 3'd2);
      8'h31: plain_map = rc(3'd7, 3'd3); 8'h32: plain_map = rc(3'd7, 3'd4);
      8'h76: plain_map = rc(3'd7, 3'd0); 8'h49: plain_map = rc(3'd7, 3'd2);
      8'h41: plain_map = rc(3'd7, 3'd3);
      8'h61: plain_map = rc(3'd0, 3'd1);
      default: plain_map = '0;
    endcase
  endfunction

  // CAPS SHIFT sources; E0 12 / E0 59 are the keyboard's fake shifts.
  function automatic cs_t cs_map(input logic [7:0] c, input logic ext);
    cs_map = '0;
    case (c)
      8'h12: if (!ext) cs_map = '{1'b1, 3'd0};
      8'h59: if (!ext) cs_map = '{1'b1, 3'd1};
      8'h75: cs_map = '{1'b1, 3'd2};  8'h72: cs_map = '{1'b1, 3'd3};
      8'h6B: cs_map = '{1'b1, 3'd4};  8'h74: cs_map = '{1'b1, 3'd5};
      8'h66: cs_map = '{1'b1, 3'd6};  8'h76: cs_map = '{1'b1, 3'd7};
      default: cs_map = '0;
    endcase
  endfunction

  // SYMBOL SHIFT sources; left and right ctrl are independent holders.
  function automatic ss_t ss_map(input logic [7:0] c, input logic ext);
    ss_map = '0;
    case (c)
      8'h54: ss_map = '{1'b1, 4'd0};  8'h52: ss_map = '{1'b1, 4'd1};
      8'h49: ss_map = '{1'b1, 4'd2};  8'h41: ss_map = '{1'b1, 4'd3};
      8'h4A: ss_map = '{1'b1, 4'd4};  8'h5B: ss_map = '{1'b1, 4'd5};
      8'h61: ss_map = '{1'b1, 4'd6};
      8'h14: ss_map = '{1'b1, ext ? 4'd8 : 4'd7};
      default: ss_map = '0;
    endcase
  endfunction

  state_t           state, state_nx;
  logic [SKW-1:0]   skip_cnt;
  logic             ev_valid, ev_make, ev_ext, skip_load, flush, is_flush;
  logic [7:0]       code;
  logic [7:0][4:0]  keys;
  logic [CNTW-1:0]  cs_cnt, ss_cnt;
  logic [7:0]       cs_held;
  logic [8:0]       ss_held;
  logic             ctrl, alt, nmi_r, rst_r;
  logic [7:0][4:0]  eff;
  logic [4:0]       q_c;
  pos_t             pmap;
  cs_t              cs_src;
  ss_t              ss_src;

  assign code     = bus.code;
  assign is_flush = (code == 8'hAA) || (code == 8'hFC) || (code == 8'hFF);
  assign flush    = bus.kstb && is_flush;
  assign pmap     = plain_map(code);
  assign cs_src   = cs_map(code, ev_ext);
  assign ss_src   = ss_map(code, ev_ext);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned and infers a latch.
  always_comb begin
    state_nx = state;
    if (bus.kstb) begin
      if (is_flush) state_nx = S_IDLE;
      else begin
        case (state)
          S_IDLE: begin
            if      (code == 8'hE0) state_nx = S_EXT;
            else if (code == 8'hF0) state_nx = S_BRK;
            else if (code == 8'hE1) state_nx = S_SKIP;
          end
          S_EXT:   state_nx = (code == 8'hF0) ? S_EXTBRK : S_IDLE;
          S_SKIP:  if (skip_cnt == SKW'(1)) state_nx = S_IDLE;
          default: state_nx = S_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    ev_valid  = 1'b0;
    ev_make   = 1'b1;
    ev_ext    = 1'b0;
    skip_load = 1'b0;
    if (bus.kstb && !is_flush) begin
      case (state)
        S_IDLE: begin
          skip_load = (code == 8'hE1);
          ev_valid  = (code != 8'hE0) && (code != 8'hF0) && (code != 8'hE1);
        end
        S_EXT: begin
          ev_valid = (code != 8'hF0);
          ev_ext   = 1'b1;
        end
        S_BRK: begin
          ev_valid = 1'b1;
          ev_make  = 1'b0;
        end
        S_EXTBRK: begin
          ev_valid = 1'b1;
          ev_make  = 1'b0;
          ev_ext   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                  skip_cnt <= '0;
    else if (skip_load)                          skip_cnt <= SKW'(E1_SKIP);
    else if (bus.kstb && !is_flush && state == S_SKIP) skip_cnt <= skip_cnt - SKW'(1);
  end

  // Held flags make a source count at most once while it is down, so
  // typematic repeats never leave a residue in the shift counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the key array is small state, not a RAM, so it resets with
      // everything else to guarantee an all-released matrix.
      keys    <= '1;
      cs_cnt  <= '0;
      ss_cnt  <= '0;
      cs_held <= '0;
      ss_held <= '0;
      ctrl    <= 1'b0;
      alt     <= 1'b0;
      nmi_r   <= 1'b0;
      rst_r   <= 1'b0;
    end else begin
      nmi_r <= 1'b0;
      rst_r <= 1'b0;
      if (flush) begin
        // Held flags go too; a set flag with a zero count would lock the key.
        keys    <= '1;
        cs_cnt  <= '0;
        ss_cnt  <= '0;
        cs_held <= '0;
        ss_held <= '0;
        ctrl    <= 1'b0;
        alt     <= 1'b0;
      end else if (ev_valid) begin
        if (ev_make && !ev_ext && code == NMI_CODE) begin
          nmi_r <= 1'b1;
        end else if (ev_make && ev_ext && code == 8'h71) begin
          rst_r <= ctrl && alt;
        end else begin
          if (pmap.hit) keys[pmap.row][pmap.col] <= ~ev_make;
          if (cs_src.hit) begin
            if (ev_make && !cs_held[cs_src.idx]) begin
              cs_held[cs_src.idx] <= 1'b1;
              if (cs_cnt != CNT_MAX) cs_cnt <= cs_cnt + CNTW'(1);
            end else if (!ev_make && cs_held[cs_src.idx]) begin
              cs_held[cs_src.idx] <= 1'b0;
              if (cs_cnt != '0) cs_cnt <= cs_cnt - CNTW'(1);
            end
          end
          if (ss_src.hit) begin
            if (ev_make && !ss_held[ss_src.idx]) begin
              ss_held[ss_src.idx] <= 1'b1;
              if (ss_cnt != CNT_MAX) ss_cnt <= ss_cnt + CNTW'(1);
            end else if (!ev_make && ss_held[ss_src.idx]) begin
              ss_held[ss_src.idx] <= 1'b0;
              if (ss_cnt != '0) ss_cnt <= ss_cnt - CNTW'(1);
            end
          end
          if (code == 8'h14) ctrl <= ev_make;
          if (code == 8'h11) alt  <= ev_make;
        end
      end
    end
  end

  // Shift keys come from the counters; the stored bits at those spots stay 1.
  always_comb begin
    eff       = keys;
    eff[0][0] = (cs_cnt == '0);
    eff[7][1] = (ss_cnt == '0);
    q_c       = '1;
    for (int r = 0; r < 8; r++) q_c = q_c & (eff[r] | {5{bus.a[r]}});
  end

  assign bus.q   = q_c;
  assign bus.nmi = nmi_r;
  assign bus.rst = rst_r;

endmodule

// File: tb/tb_ps2_matrix.sv
// tb_ps2_matrix -- directed scenarios plus randomized byte streams checked
// against a keyboard-level reference model (prefix flags, key table, counts).
module tb_ps2_matrix;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  ps2_matrix_if bus();
  ps2_matrix dut (.clock(clock), .reset(reset), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ZX layout: row r, column c holds the scancode wired there (00 = shift spot).
  logic [7:0] layout [8][5] = '{
    '{8'h00, 8'h1A, 8'h22, 8'h21, 8'h2A},
    '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34},
    '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C},
    '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E},
    '{8'h45, 8'h46, 8'h3E, 8'h3D, 8'h36},
    '{8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35},
    '{8'h5A, 8'h4B, 8'h42, 8'h3B, 8'h33},
    '{8'h29, 8'h00, 8'h3A, 8'h31, 8'h32}};
  // Counted sources and their partner key as row*5+col (-1 = none).
  logic [7:0] cs_codes [8] = '{8'h12, 8'h59, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h66, 8'h76};
  int         cs_part  [8] = '{-1, -1, 23, 24, 19, 22, 20, 35};
  logic [7:0] ss_codes [9] = '{8'h54, 8'h52, 8'h49, 8'h41, 8'h4A, 8'h5B, 8'h61, 8'h14, 8'h14};
  int         ss_part  [9] = '{25, 26, 37, 38, 33, 32, 1, -1, -1};

  bit m_key [8][5];
  int m_cs, m_ss, m_skip;
  bit m_csh [8];
  bit m_ssh [9];
  bit m_ctrl, m_alt, m_e0, m_f0, exp_nmi, exp_rst;

  task automatic model_clear();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 5; c++) m_key[r][c] = 1;
    for (int i = 0; i < 8; i++) m_csh[i] = 0;
    for (int i = 0; i < 9; i++) m_ssh[i] = 0;
    m_cs = 0; m_ss = 0; m_ctrl = 0; m_alt = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_e0 = 0; m_f0 = 0; m_skip = 0; exp_nmi = 0; exp_rst = 0;
  endtask

  task automatic count(inout int cnt, inout bit held, input bit make);
    if (make && !held) begin held = 1; if (cnt < 7) cnt++; end
    else if (!make && held) begin held = 0; if (cnt > 0) cnt--; end
  endtask

  task automatic apply_event(input logic [7:0] b, input bit make, input bit ext);
    if (make && !ext && b == 8'h03) begin exp_nmi = 1; return; end
    if (make && ext && b == 8'h71) begin exp_rst = m_ctrl && m_alt; return; end
    if (ext && (b == 8'h12 || b == 8'h59)) return;
    if (b == 8'h14) m_ctrl = make;
    if (b == 8'h11) m_alt = make;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 5; c++)
        if (b != 8'h00 && layout[r][c] == b) m_key[r][c] = !make;
    for (int i = 0; i < 8; i++)
      if (cs_codes[i] == b) begin
        count(m_cs, m_csh[i], make);
        if (cs_part[i] >= 0) m_key[cs_part[i] / 5][cs_part[i] % 5] = !make;
      end
    for (int i = 0; i < 9; i++)
      if (ss_codes[i] == b && (b != 8'h14 || ((i == 8) == ext))) begin
        count(m_ss, m_ssh[i], make);
        if (ss_part[i] >= 0) m_key[ss_part[i] / 5][ss_part[i] % 5] = !make;
      end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hAA || b == 8'hFC || b == 8'hFF) begin
      model_clear(); m_e0 = 0; m_f0 = 0; m_skip = 0; return;
    end
    if (m_skip > 0) begin m_skip--; return; end
    if (!m_e0 && !m_f0 && b == 8'hE1) begin m_skip = 7; return; end
    if (!m_e0 && !m_f0 && b == 8'hE0) begin m_e0 = 1; return; end
    if (!m_f0 && b == 8'hF0) begin m_f0 = 1; return; end
    apply_event(b, !m_f0, m_e0);
    m_e0 = 0; m_f0 = 0;
  endtask

  function automatic logic [4:0] model_q(input logic [7:0] av);
    logic [4:0] res = 5'h1F;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 8; r++) begin
        bit kb = m_key[r][c];
        if (r == 0 && c == 0) kb = (m_cs == 0);
        if (r == 7 && c == 1) kb = (m_ss == 0);
        if (!av[r] && !kb) res[c] = 1'b0;
      end
    return res;
  endfunction

  // One clock: check outputs left by the previous byte, then drive the next.
  task automatic tick(input bit kv, input logic [7:0] b, input logic [7:0] av);
    @(negedge clock);
    bus.a = av;
    #1;
    check("q_model", bus.q, model_q(av));
    check("nmi_model", bus.nmi, exp_nmi);
    check("rst_model", bus.rst, exp_rst);
    exp_nmi = 0; exp_rst = 0;
    bus.kstb = kv;
    bus.code = b;
    if (kv) model_byte(b);
  endtask

  task automatic send(input logic [7:0] b);
    tick(1'b1, b, 8'hFF);
  endtask

  task automatic look(input logic [7:0] av);
    tick(1'b0, 8'h00, av);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.kstb = 1'b0;
    model_reset();
    bus.a = 8'h00;
    #1;
    check("reset_q", bus.q, 5'h1F);
    check("reset_nmi", bus.nmi, 1'b0);
    check("reset_rst", bus.rst, 1'b0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  logic [7:0] pool [] = '{8'h1A, 8'h22, 8'h21, 8'h2A, 8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34,
    8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h45, 8'h46,
    8'h3E, 8'h3D, 8'h36, 8'h4D, 8'h44, 8'h43, 8'h3C, 8'h35, 8'h5A, 8'h4B, 8'h42, 8'h3B,
    8'h33, 8'h29, 8'h3A, 8'h31, 8'h32, 8'h12, 8'h59, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h66,
    8'h76, 8'h54, 8'h52, 8'h49, 8'h41, 8'h4A, 8'h5B, 8'h61, 8'h14, 8'h11, 8'h0D, 8'h77};

  initial begin
    logic [7:0] fl [3];
    bus.kstb = 1'b0; bus.code = 8'h00; bus.a = 8'hFF;
    model_reset();
    repeat (2) @(negedge clock);
    do_reset();

    // Plain key make / break.
    send(8'h1C); look(8'hFD); check("a_make", bus.q, 5'b11110);
    send(8'hF0); send(8'h1C); look(8'hFD); check("a_break", bus.q, 5'b11111);

    // Shared CS: releasing the arrow keeps shift down.
    send(8'h12); send(8'h75); send(8'hF0); send(8'h75);
    look(8'hFE); check("cs_shared", bus.q[0], 1'b0);
    send(8'hF0); send(8'h12); look(8'hFE); check("cs_released", bus.q[0], 1'b1);

    // Typematic repeat on shift leaves no residue.
    send(8'h12); send(8'h12); send(8'h12); send(8'hF0); send(8'h12);
    look(8'hFE); check("cs_repeat", bus.q, 5'b11111);

    // Unheld SS break, then a swallowed Pause sequence, then A.
    send(8'hE0); send(8'hF0); send(8'h14); look(8'h7F); check("ss_unheld", bus.q, 5'b11111);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14);
    send(8'hF0); send(8'h77); send(8'h1C);
    look(8'h7F); check("pause_ss", bus.q[1], 1'b1);
    look(8'hFD); check("pause_a", bus.q, 5'b11110);
    do_reset();

    // Ctrl+Alt+Del, NMI, then Del without alt.
    send(8'h14); send(8'h11); send(8'hE0); send(8'h71);
    look(8'hFF); check("rst_pulse", bus.rst, 1'b1);
    look(8'hFF); check("rst_width", bus.rst, 1'b0);
    send(8'h03); look(8'hFF); check("nmi_pulse", bus.nmi, 1'b1);
    look(8'hFF); check("nmi_width", bus.nmi, 1'b0);
    send(8'hF0); send(8'h11); send(8'hE0); send(8'h71);
    look(8'hFF); check("rst_no_alt", bus.rst, 1'b0);

    // Flush byte releases everything.
    send(8'h1C); send(8'h12); send(8'hAA);
    look(8'h00); check("flush_q", bus.q, 5'b11111);

    // CS counter saturation with all eight sources held.
    fl = '{8'hAA, 8'hFC, 8'hFF};
    for (int i = 0; i < 8; i++) send(cs_codes[i]);
    for (int i = 0; i < 7; i++) begin send(8'hF0); send(cs_codes[i]); end
    look(8'hFE); check("cs_saturate", bus.q[0], 1'b1);
    send(8'hF0); send(cs_codes[7]); look(8'hFE); check("cs_drained", bus.q[0], 1'b1);

    // Reset mid-sequence: the following byte starts from IDLE.
    send(8'hE0); do_reset(); send(8'h75);
    look(8'hEF); check("abort_75", bus.q, 5'b10111);
    send(8'hE0); do_reset(); send(8'h12);
    look(8'hFE); check("abort_shift", bus.q[0], 1'b0);
    do_reset();

    // Randomized byte stream.
    for (int n = 0; n < 4000; n++) begin
      int unsigned r = $urandom_range(0, 99);
      logic [7:0] b, av;
      bit kv = ($urandom_range(0, 9) < 8);
      if      (r < 20) b = 8'hF0;
      else if (r < 26) b = 8'hE0;
      else if (r < 28) b = 8'hE1;
      else if (r < 29) b = fl[$urandom_range(0, 2)];
      else if (r < 32) b = 8'h03;
      else if (r < 35) b = 8'h71;
      else             b = pool[$urandom_range(0, pool.size() - 1)];
      if ($urandom_range(0, 1) == 1) av = ~(8'h01 << $urandom_range(0, 7));
      else                           av = 8'($urandom);
      tick(kv, b, av);
    end
    look(8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
